// File: rtl/proc_pkg.sv
// proc_pkg: processor-wide widths and the write-back entry type
package proc_pkg;
   localparam int ARCH_BITS = 32;
   localparam int REG_ADDR_BITS = 5;
   typedef struct packed {
      logic [REG_ADDR_BITS-1:0] dst;
      logic [ARCH_BITS-1:0] data;
   } entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// wb_queue_if: producer handshakes, register-file write port and forwarding lookups of the write-back queue
interface wb_queue_if;
   import proc_pkg::*;
   logic mem_valid, mem_ready;
   logic [REG_ADDR_BITS-1:0] mem_dst;
   logic [ARCH_BITS-1:0] mem_data;
   logic alu_valid, alu_ready;
   logic [REG_ADDR_BITS-1:0] alu_dst;
   logic [ARCH_BITS-1:0] alu_data;
   logic rf_we;
   logic [REG_ADDR_BITS-1:0] rf_dst;
   logic [ARCH_BITS-1:0] rf_wdata;
   logic [REG_ADDR_BITS-1:0] q1_src, q2_src;
   logic q1_hit, q2_hit;
   logic [ARCH_BITS-1:0] q1_data, q2_data;
   modport slave(
      input mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data, q1_src, q2_src,
      output mem_ready, alu_ready, rf_we, rf_dst, rf_wdata, q1_hit, q2_hit, q1_data, q2_data
   );
   modport master(
      output mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data, q1_src, q2_src,
      input mem_ready, alu_ready, rf_we, rf_dst, rf_wdata, q1_hit, q2_hit, q1_data, q2_data
   );
endinterface

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest queued entry whose destination matches the query register
module wb_fwd_match
   import proc_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  entry_t ents [DEPTH],
   input  logic [PW-1:0] head,
   input  logic [PW:0] count,
   input  logic [REG_ADDR_BITS-1:0] src,
   output logic hit,
   output logic [ARCH_BITS-1:0] data
);
   // walk oldest to youngest so the last match found is the youngest one
   always_comb begin
      hit = 1'b0;
      data = '0;
      for (int i = 0; i < DEPTH; i++)
         if ((PW+1)'(i) < count && ents[head + PW'(i)].dst == src) begin
            hit = 1'b1;
            data = ents[head + PW'(i)].data;
         end
   end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back FIFO feeding the register-file write port, with two forwarding lookups
module wb_queue
   import proc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   wb_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   entry_t ents [DEPTH];
   logic [PW-1:0] head, tail;
   logic [PW:0] count, free;
   logic busy, mem_acc, alu_acc;
   assign busy = count != '0;
   assign free = (PW+1)'(DEPTH) - count + (PW+1)'(busy);
   assign bus.mem_ready = !rst && free != '0;
   assign bus.alu_ready = !rst && (free >= (PW+1)'(2) || (free == (PW+1)'(1) && !bus.mem_valid));
   assign mem_acc = bus.mem_valid && bus.mem_ready;
   assign alu_acc = bus.alu_valid && bus.alu_ready;
   assign bus.rf_we = busy && !rst;
   assign bus.rf_dst = bus.rf_we ? ents[head].dst : '0;
   assign bus.rf_wdata = bus.rf_we ? ents[head].data : '0;
   // pointers and occupancy: pop the head whenever non-empty, advance tail by accepted entries
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         head <= head + PW'(busy);
         tail <= tail + PW'(mem_acc) + PW'(alu_acc);
         count <= count + (PW+1)'(mem_acc) + (PW+1)'(alu_acc) - (PW+1)'(busy);
      end
   end
   // mem is the older instruction, so it lands before the alu entry
   always_ff @(posedge clk) begin
      if (mem_acc) ents[tail] <= '{dst: bus.mem_dst, data: bus.mem_data};
      if (alu_acc) ents[tail + PW'(mem_acc)] <= '{dst: bus.alu_dst, data: bus.alu_data};
   end
   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
      .ents(ents), .head(head), .count(count), .src(bus.q1_src), .hit(bus.q1_hit), .data(bus.q1_data)
   );
   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
      .ents(ents), .head(head), .count(count), .src(bus.q2_src), .hit(bus.q2_hit), .data(bus.q2_data)
   );
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed stimulus with a scoreboard of accepted entries checked against register-file writes
module tb_wb_queue;
   import proc_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   wb_queue_if bus();
   wb_queue dut(.clk(clk), .rst(rst), .bus(bus));
   entry_t sb[$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                       input logic av, input logic [4:0] ad, input logic [31:0] adat);
      @(posedge clk);
      #2;
      rst = r;
      bus.mem_valid = mv;
      bus.mem_dst = md;
      bus.mem_data = mdat;
      bus.alu_valid = av;
      bus.alu_dst = ad;
      bus.alu_data = adat;
      #1;
   endtask

   task automatic acc();
      if (bus.mem_valid && bus.mem_ready) sb.push_back({bus.mem_dst, bus.mem_data});
      if (bus.alu_valid && bus.alu_ready) sb.push_back({bus.alu_dst, bus.alu_data});
   endtask

   // monitor: every register-file write must match the oldest accepted entry
   always @(negedge clk) begin
      if (bus.rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            chk("rf_we_unexpected", {27'd0, bus.rf_dst}, 32'hffff_ffff);
         end else begin
            entry_t e;
            e = sb.pop_front();
            chk("rf_dst", {27'd0, bus.rf_dst}, {27'd0, e.dst});
            chk("rf_wdata", bus.rf_wdata, e.data);
         end
      end
   end

   initial begin
      int cm, fr, ai, guard;
      logic ma, aa;
      bus.mem_valid = 0; bus.mem_dst = 0; bus.mem_data = 0;
      bus.alu_valid = 0; bus.alu_dst = 0; bus.alu_data = 0;
      bus.q1_src = 5'd3; bus.q2_src = 5'd9;
      @(posedge clk);
      @(posedge clk);
      #3;
      chk("rst_mem_ready", bus.mem_ready, 0);
      chk("rst_alu_ready", bus.alu_ready, 0);
      chk("rst_rf_we", bus.rf_we, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("idle_rf_we", bus.rf_we, 0);
      chk("idle_rf_dst", bus.rf_dst, 0);
      chk("idle_rf_wdata", bus.rf_wdata, 0);
      chk("idle_mem_ready", bus.mem_ready, 1);
      chk("idle_alu_ready", bus.alu_ready, 1);
      chk("idle_q1_hit", bus.q1_hit, 0);
      chk("idle_q1_data", bus.q1_data, 0);
      chk("idle_q2_hit", bus.q2_hit, 0);
      acc();
      // single alu write r5 = 0x1234
      step(0, 0, 0, 0, 1, 5'd5, 32'h1234);
      chk("single_alu_ready", bus.alu_ready, 1);
      chk("single_q1_not_yet", bus.q1_hit, 0);
      acc();
      bus.q1_src = 5'd5;
      step(0, 0, 0, 0, 0, 0, 0);
      chk("single_rf_we", bus.rf_we, 1);
      chk("single_rf_dst", bus.rf_dst, 5);
      chk("single_rf_wdata", bus.rf_wdata, 32'h1234);
      chk("single_q1_hit", bus.q1_hit, 1);
      chk("single_q1_data", bus.q1_data, 32'h1234);
      acc();
      step(0, 0, 0, 0, 0, 0, 0);
      chk("single_drained_we", bus.rf_we, 0);
      chk("single_count", dut.count, 0);
      chk("single_q1_gone", bus.q1_hit, 0);
      chk("single_q1_data0", bus.q1_data, 0);
      acc();
      // mem r2 = 0xAA and alu r2 = 0xBB together
      bus.q1_src = 5'd2;
      bus.q2_src = 5'd2;
      step(0, 1, 5'd2, 32'hAA, 1, 5'd2, 32'hBB);
      chk("pair_mem_ready", bus.mem_ready, 1);
      chk("pair_alu_ready", bus.alu_ready, 1);
      acc();
      step(0, 0, 0, 0, 0, 0, 0);
      chk("pair_count", dut.count, 2);
      chk("pair_first_wdata", bus.rf_wdata, 32'hAA);
      chk("pair_q1_hit", bus.q1_hit, 1);
      chk("pair_q1_young", bus.q1_data, 32'hBB);
      chk("pair_q2_young", bus.q2_data, 32'hBB);
      acc();
      step(0, 0, 0, 0, 0, 0, 0);
      chk("pair_second_wdata", bus.rf_wdata, 32'hBB);
      chk("pair_q1_last", bus.q1_data, 32'hBB);
      acc();
      step(0, 0, 0, 0, 0, 0, 0);
      chk("pair_drained_we", bus.rf_we, 0);
      acc();
      // reset with three entries queued
      bus.q1_src = 5'd12;
      step(0, 1, 5'd10, 32'hA10, 1, 5'd11, 32'hA11);
      acc();
      step(0, 1, 5'd12, 32'hA12, 1, 5'd13, 32'hA13);
      acc();
      step(1, 0, 0, 0, 0, 0, 0);
      chk("midrst_count_before", dut.count, 3);
      chk("midrst_rf_we", bus.rf_we, 0);
      chk("midrst_mem_ready", bus.mem_ready, 0);
      chk("midrst_alu_ready", bus.alu_ready, 0);
      sb.delete();
      step(0, 0, 0, 0, 0, 0, 0);
      chk("postrst_count", dut.count, 0);
      chk("postrst_rf_we", bus.rf_we, 0);
      chk("postrst_q1_hit", bus.q1_hit, 0);
      chk("postrst_mem_ready", bus.mem_ready, 1);
      chk("postrst_alu_ready", bus.alu_ready, 1);
      acc();
      // both producers valid every cycle; alu holds its offer until accepted
      cm = 0;
      ai = 0;
      for (int k = 0; k < 8; k++) begin
         step(0, 1, 5'(k), 32'h1000 + k, 1, 5'(16 + ai), 32'h2000 + ai);
         fr = 4 - cm + (cm != 0 ? 1 : 0);
         chk("burst_mem_ready", bus.mem_ready, fr >= 1);
         chk("burst_alu_ready", bus.alu_ready, fr >= 2);
         chk("burst_rf_we", bus.rf_we, k >= 1);
         if (k == 3) chk("burst_full_count", dut.count, 4);
         ma = bus.mem_valid && bus.mem_ready;
         aa = bus.alu_valid && bus.alu_ready;
         acc();
         if (aa) ai++;
         cm = cm + int'(ma) + int'(aa) - (cm != 0 ? 1 : 0);
      end
      // full queue, mem idle: alu takes the single free slot
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 1, 5'(16 + ai), 32'h2000 + ai);
         chk("full_alu_ready", bus.alu_ready, 1);
         chk("full_mem_ready", bus.mem_ready, 1);
         chk("full_rf_we", bus.rf_we, 1);
         chk("full_count", dut.count, 4);
         acc();
         ai++;
      end
      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         step(0, 0, 0, 0, 0, 0, 0);
         acc();
         guard++;
      end
      chk("drain_scoreboard_empty", sb.size(), 0);
      chk("drain_rf_we", bus.rf_we, 0);
      chk("drain_count", dut.count, 0);
      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue that sits directly upstream of the register file's single write port. It accepts results from two producers, the ALU and memory load, each with a valid/ready handshake, and buffers them in a small in-order FIFO. It drains one entry per cycle into the register file (`writeEnable`/`dst`/`wData`). It also provides two forwarding lookups so decode can read values not yet written.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ARCH_BITS`, `proc_pkg::ARCH_BITS`: data width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_valid` in 1: load result offered.
- `mem_ready` out 1: load result accepted this edge if valid.
- `mem_dst` in 5: destination register.
- `mem_data` in ARCH_BITS: load data.
- `alu_valid` in 1: ALU result offered.
- `alu_ready` out 1: ALU result accepted this edge if valid.
- `alu_dst` in 5: destination register.
- `alu_data` in ARCH_BITS: ALU data.
- `rf_we` out 1: drives register-file `writeEnable`.
- `rf_dst` out 5: drives register-file `dst`.
- `rf_wdata` out ARCH_BITS: drives register-file `wData`.
- `q1_src`, `q2_src` in 5: forwarding query registers.
- `q1_hit`, `q2_hit` out 1: a queued entry targets the queried register.
- `q1_data`, `q2_data` out ARCH_BITS: data of the youngest matching entry; 0 when no hit.

## Operation
- Storage: DEPTH entries of {dst, data}; head and tail pointers of log2(DEPTH) bits with natural wrap; count of log2(DEPTH)+1 bits.
- Drain: whenever count≠0, the head entry is presented on `rf_we`=1/`rf_dst`/`rf_wdata` and popped at the next edge. The register file accepts unconditionally.
- Free slots this cycle: `free = DEPTH − count + (count≠0 ? 1 : 0)`. The pop frees a slot in the same cycle.
- Ready rules:
  - `mem_ready = (free ≥ 1)`.
  - `alu_ready = (free ≥ 2) || (free == 1 && !mem_valid)`.
  - mem has priority, being the older instruction.
  - Readies are combinational and depend on the valid of the other port only.
- Enqueue: if both are accepted in one edge, the mem entry goes at the tail and the alu entry at tail+1 (program order). Tail advances by the number of accepted entries.
- Count update: count_next = count + accepted − popped. This covers 0/1/2 enqueues with or without a simultaneous pop.
- No r0 special case: every destination, including 0, is written.
- Forwarding:
  - Compare each query against all valid entries (positions head … head+count−1).
  - Report the youngest match, i.e. closest to the tail.
  - Entries accepted in the current cycle are not visible; the entry being popped this cycle is visible.
  - Purely combinational.
- Duplicate destinations in the queue are legal; they drain in order, so the last write wins.

## Timing
- Reset: count, head and tail become 0. In the cycle after reset: `rf_we`=0, `rf_dst`=0, `rf_wdata`=0, `q*_hit`=0, `q*_data`=0, `mem_ready`=1, `alu_ready`=1.
- During the `rst`-high cycle: `mem_ready`=`alu_ready`=0, no accepts, no `rf_we`.
- Reset mid-operation discards all queued entries without writing them.
- Latency: an entry accepted at edge k into an empty queue shows `rf_we`=1 in cycle k→k+1 and is written into the register file at edge k+1.
- Throughput: one write per cycle sustained. Two-producer bursts fill the queue at one net entry per cycle.
- When full (count=DEPTH), free=1: mem can be accepted, and alu only when mem is idle. The queue never overflows or underflows.
- Outputs `rf_*` and `q*_data` are driven from registered storage only; there is no input-to-`rf_*` combinational path.

## Structure
- `proc_pkg` holds `ARCH_BITS`, `REG_ADDR_BITS`=5, and the entry typedef {dst, data}. The register file uses the same package.
- One sub-module, `wb_fwd_match`: a youngest-match search over the entry array given head and count, instantiated twice (q1, q2).

## Test plan
- Reset then idle → `rf_we`=0, both readies 1, `q1_hit`=0 with `q1_src`=3.
- Single alu write r5=0x1234 at edge 1 → at edge 2 `rf_we`=1, `rf_dst`=5, `rf_wdata`=0x1234; count back to 0 after edge 2; `q1_src`=5 hits with 0x1234 during that cycle.
- mem r2=0xAA and alu r2=0xBB in the same cycle → drain order 0xAA then 0xBB on consecutive cycles; query r2 reports 0xBB while both are queued.
- Both ports valid every cycle with DEPTH=4:
  - Queue fills after 3 cycles.
  - Thereafter `mem_ready`=1 and `alu_ready`=0.
  - `rf_we` stays continuously 1.
  - No entry is lost or duplicated; check against a scoreboard.
- With 3 entries queued, assert `rst` → next cycle `rf_we`=0, count 0, and none of the 3 dsts are written.
- Full queue, mem idle, alu valid → alu accepted (free=1), count stays DEPTH, one write per cycle.
